// File: rtl/rpn_eval_ctrl.sv
// rpn_eval_ctrl: postfix token evaluator with an internal operand stack and an iterative divider.
module rpn_eval_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_stb,
  input  logic [WIDTH-1:0] tok_dat,
  input  logic             tok_op,
  output logic             tok_ack,
  output logic             res_stb,
  output logic [WIDTH-1:0] res_dat,
  output logic [1:0]       res_err,
  input  logic             res_ack
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {WAIT, EXEC, DIV, ACK, RESULT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [PW-1:0]    depth_q, depth_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tok_ack_q, tok_ack_d, res_stb_q, res_stb_d;
  logic [WIDTH-1:0] res_dat_q, res_dat_d;
  logic [1:0]       res_err_q, res_err_d;
  logic [AW-1:0]    top_i, sec_i, psh_i;
  logic [WIDTH-1:0] a, b, alu, quo_n, q_fix;
  logic [WIDTH:0]   trial;
  logic [2:0]       opc;
  logic [1:0]       end_err;
  logic             full, two;
  assign top_i   = AW'(depth_q - PW'(1));
  assign sec_i   = AW'(depth_q - PW'(2));
  assign psh_i   = AW'(depth_q);
  assign a       = stk_q[sec_i];
  assign b       = stk_q[top_i];
  assign opc     = tok_dat[2:0];
  assign full    = depth_q == PW'(DEPTH);
  assign two     = depth_q >= PW'(2);
  assign alu     = opc == 3'd0 ? a + b : opc == 3'd1 ? a - b : a * b;
  // One restoring step: shift in the next dividend bit, keep the difference unless it borrowed
  assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign q_fix   = neg_q ? -quo_n : quo_n;
  assign end_err = err_q != 2'd0 ? err_q : depth_q == '0 ? 2'd1 : depth_q != PW'(1) ? 2'd2 : 2'd0;
  assign tok_ack = tok_ack_q;
  assign res_stb = res_stb_q;
  assign res_dat = res_dat_q;
  assign res_err = res_err_q;
  always_comb begin
    state_d   = state_q;
    stk_d     = stk_q;
    depth_d   = depth_q;
    err_d     = err_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    tok_ack_d = 1'b0;
    res_stb_d = res_stb_q;
    res_dat_d = res_dat_q;
    res_err_d = res_err_q;
    case (state_q)
      WAIT: state_d = tok_stb ? EXEC : WAIT;
      EXEC: begin
        if (tok_op && opc == 3'd4) begin
          err_d     = end_err;
          res_err_d = end_err;
          res_dat_d = end_err == 2'd0 ? b : '0;
          res_stb_d = 1'b1;
          state_d   = RESULT;
        end else begin
          state_d   = ACK;
          tok_ack_d = 1'b1;
          if (err_q == 2'd0 && !tok_op) begin
            if (full) err_d = 2'd2;
            else begin
              stk_d[psh_i] = tok_dat;
              depth_d      = depth_q + PW'(1);
            end
          end else if (err_q == 2'd0 && opc <= 3'd3) begin
            if (!two) err_d = 2'd1;
            else if (opc != 3'd3) begin
              stk_d[sec_i] = alu;
              depth_d      = depth_q - PW'(1);
            end else if (b == '0) err_d = 2'd3;
            else begin
              rem_d     = '0;
              quo_d     = a[WIDTH-1] ? -a : a;
              dvs_d     = b[WIDTH-1] ? -b : b;
              neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
              cnt_d     = '0;
              tok_ack_d = 1'b0;
              state_d   = DIV;
            end
          end
        end
      end
      DIV: begin
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_d = quo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          stk_d[sec_i] = q_fix;
          depth_d      = depth_q - PW'(1);
          tok_ack_d    = 1'b1;
          state_d      = ACK;
        end
      end
      ACK: state_d = WAIT;
      RESULT: begin
        if (res_ack) begin
          res_stb_d = 1'b0;
          tok_ack_d = 1'b1;
          depth_d   = '0;
          err_d     = 2'd0;
          state_d   = ACK;
        end
      end
      default: state_d = WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT;
      stk_q     <= '{default: '0};
      depth_q   <= '0;
      err_q     <= 2'd0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      tok_ack_q <= 1'b0;
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
      res_err_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      stk_q     <= stk_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      tok_ack_q <= tok_ack_d;
      res_stb_q <= res_stb_d;
      res_dat_q <= res_dat_d;
      res_err_q <= res_err_d;
    end
  end
endmodule
